// File: rtl/multiply_const_seq.sv
// ============================================================================
// Module   : multiply_const_seq
// Brief    : Sequential shift-add multiplier of an unsigned operand by a fixed
//            constant, one constant bit per clock, Start/Busy/Done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiply_const_seq #(
    parameter int unsigned IN_W     = 4,
    parameter int unsigned CONST    = 100,
    parameter int unsigned CONST_W  = 7,
    parameter int unsigned OUT_W    = 10,
    parameter int unsigned SATURATE = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [IN_W-1:0]  Operand_In,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic [OUT_W-1:0] Multi_Out
);

    localparam int unsigned FW    = IN_W + CONST_W;
    localparam int unsigned IDX_W = (CONST_W > 1) ? $clog2(CONST_W) : 1;
    localparam logic [CONST_W-1:0] c_const_bits = CONST_W'(CONST);
    localparam logic [IDX_W-1:0]   c_last_idx   = IDX_W'(CONST_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IN_W-1:0]    r_operand;
    logic [FW-1:0]      r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [OUT_W-1:0]   r_out;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic [FW-1:0]      w_addend;
    logic [FW-1:0]      w_sum;
    logic [OUT_W-1:0]   w_trunc;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_result;

    assign w_last   = (r_idx == c_last_idx);
    assign w_addend = c_const_bits[r_idx] ? (FW'(r_operand) << r_idx) : '0;
    assign w_sum    = r_acc + w_addend;

    // Overflow can only exist when the output is narrower than the full product.
    generate
        if (OUT_W >= FW) begin : g_no_ovf
            assign w_trunc = OUT_W'(w_sum);
            assign w_ovf   = 1'b0;
        end else begin : g_ovf
            assign w_trunc = w_sum[OUT_W-1:0];
            assign w_ovf   = |w_sum[FW-1:OUT_W];
        end
    endgenerate

    assign w_result = ((SATURATE != 0) && w_ovf) ? {OUT_W{1'b1}} : w_trunc;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Busy/Done are registered from the next state so they align with r_state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_operand <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_out     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_operand <= Operand_In;
                        r_acc     <= '0;
                        r_idx     <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_out <= w_result;
                        r_ovf <= w_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Overflow  = r_ovf;
    assign Multi_Out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_multiply_const_seq.sv
// ============================================================================
// Module   : tb_multiply_const_seq
// Brief    : Directed scoreboard bench for multiply_const_seq (truncating and
//            saturating instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiply_const_seq;

    localparam int IN_W    = 4;
    localparam int CONST   = 100;
    localparam int CONST_W = 7;
    localparam int OUT_W   = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [IN_W-1:0]  op = '0;
    logic             busy, done, ovf;
    logic [OUT_W-1:0] out;
    logic             s_busy, s_done, s_ovf;
    logic [OUT_W-1:0] s_out;

    multiply_const_seq #(.IN_W(IN_W), .CONST(CONST), .CONST_W(CONST_W),
                         .OUT_W(OUT_W), .SATURATE(0)) u_dut (
        .Clk(clk), .Reset(rst), .Start(start), .Operand_In(op),
        .Busy(busy), .Done(done), .Overflow(ovf), .Multi_Out(out)
    );

    multiply_const_seq #(.IN_W(IN_W), .CONST(CONST), .CONST_W(CONST_W),
                         .OUT_W(OUT_W), .SATURATE(1)) u_dut_sat (
        .Clk(clk), .Reset(rst), .Start(start), .Operand_In(op),
        .Busy(s_busy), .Done(s_done), .Overflow(s_ovf), .Multi_Out(s_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] out;
        logic             ovf;
        logic [OUT_W-1:0] sat_out;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [OUT_W-1:0] cur_out  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int v);
        exp_t e;
        int   p;
        p         = v * CONST;
        e.out     = OUT_W'(p % 1024);
        e.ovf     = (p > 1023);
        e.sat_out = e.ovf ? OUT_W'(1023) : OUT_W'(p % 1024);
        return e;
    endfunction

    // Results are scored whenever a completion pulse is seen.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("multi_out", 32'(out), 32'(mon_e.out));
                check("overflow", 32'(ovf), 32'(mon_e.ovf));
                check("sat_multi_out", 32'(s_out), 32'(mon_e.sat_out));
                check("sat_overflow", 32'(s_ovf), 32'(mon_e.ovf));
                check("sat_done_align", 32'(s_done), 1);
                cur_out = mon_e.out;
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ovf"},  32'(ovf), 0);
        check({tag, "_out"},  32'(out), 0);
        check({tag, "_sat_out"}, 32'(s_out), 0);
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the Done pulse.
    task automatic run_op(input int v);
        int lat;
        lat = 0;
        start = 1'b1;
        op    = IN_W'(v);
        sb.push_back(model(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~IN_W'(v);
        check("busy_after_start", 32'(busy), 1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
            else      check("hold_out", 32'(out), 32'(cur_out));
        end
        check("done_latency", 32'(lat), CONST_W);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_op(9);
        run_op(15);
        run_op(9);
        run_op(0);

        // Start held high: back-to-back ops every 9 cycles, operand changes mid-RUN ignored.
        start = 1'b1;
        op    = 4'd3;
        repeat (3) sb.push_back(model(3));
        @(posedge clk);
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk);
            #1;
            check("held_done", 32'(done), 32'((k % 9) == 7));
            check("held_busy", 32'(busy), 32'(((k % 9) != 8) && (k != 27)));
            if (k == 3 || k == 12 || k == 21) op = 4'd5;
            if (k == 6 || k == 15)            op = 4'd3;
            if (k == 26)                      start = 1'b0;
        end

        run_op(15);

        // Asynchronous reset with idx=3 aborts the operation.
        start = 1'b1;
        op    = 4'd11;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_reset");
        cur_out = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("no_done_after_abort", 32'(done), 0);
        end
        run_op(7);

        for (int v = 0; v < 16; v++) run_op(v);

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
